fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the PC, issues requests to the icache port, and produces the write-side inputs for the IF/ID pipeline register (pcplus4, instr, next_pc, writeEN, flush).
- Sits between the icache request/hit interface and the IF/ID latch.
- Absorbs downstream stalls and branch/jump redirects, including redirects that land while an icache miss is outstanding.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, width of PC and instruction words

Ports:
CLK  input  1  system clock; all state updates on rising edge
nRST  input  1  asynchronous, active-low reset
ihit  input  1  icache returns valid instruction this cycle
iload  input  WORD_W  instruction data, valid when ihit=1
imemREN  output  1  icache read request
imemaddr  output  WORD_W  icache read address
stall  input  1  downstream (hazard unit) cannot accept a new IF/ID entry this cycle
redirect_valid  input  1  single-cycle pulse from EX: branch taken or jump resolved
redirect_pc  input  WORD_W  target PC, valid with redirect_valid
halt  input  1  HALT decoded in ID; freeze fetch
ifid_writeEN  output  1  drives IF/ID writeEN
ifid_flush  output  1  drives IF/ID flush
pcplus4_out  output  WORD_W  PC+4 of the delivered instruction
instr_out  output  WORD_W  delivered instruction
next_pc_out  output  WORD_W  sequential next PC of the delivered instruction (PC+4)

Behaviour:
- Reset (async, nRST=0): pc=PC_INIT, state=FETCH, buffer cleared, squash=0. All data outputs are 0. ifid_writeEN=0, ifid_flush=0. imemREN is 1 from the first cycle after reset release.
- State machine: FETCH, HOLD, SQUASH, HALTED.
- FETCH:
  - imemREN=1, imemaddr=pc.
  - On ihit & !stall: ifid_writeEN=1, instr_out=iload, pcplus4_out=next_pc_out=pc+4, and pc<=pc+4 at the edge. Latency: the instruction reaches IF/ID on the same edge as ihit.
  - On ihit & stall: capture iload and pc+4 into the buffer, then go to HOLD. pc is unchanged; ifid_writeEN=0.
  - On !ihit: hold, ifid_writeEN=0.
- HOLD:
  - imemREN=0. Outputs present the buffered values.
  - ifid_writeEN = !stall. When stall=0: pc<=pc+4, then go to FETCH.
- Redirect (highest priority, any state except HALTED):
  - ifid_flush=1 and ifid_writeEN=0 in the redirect cycle. The buffer is discarded and pc<=redirect_pc.
  - If the current state is FETCH with !ihit (miss outstanding), go to SQUASH and hold imemaddr at the old pc. Otherwise go to FETCH.
- SQUASH:
  - imemREN=1, imemaddr=old pc, ifid_writeEN=0.
  - On ihit: discard iload and go to FETCH at redirect_pc.
  - A second redirect_valid while in SQUASH overwrites the target; the state stays SQUASH.
- Halt:
  - In FETCH or HOLD, halt=1 with no redirect_valid → HALTED.
  - redirect_valid in the same cycle wins, because halt then comes from a wrong-path instruction.
  - HALTED: imemREN=0, ifid_writeEN=0, pc frozen. Only nRST exits.
- Arithmetic: pc+4 is modulo 2^WORD_W; 32'hFFFF_FFFC wraps to 0 with no flag.
- stall has no effect on flush: a redirect during stall still flushes.
- redirect_pc is used as given (no alignment check).
- Reset mid-miss: state returns to FETCH at PC_INIT, and a late ihit for the old address is treated as a hit for PC_INIT. The icache is reset together with this block, so no ihit for the old address can arrive after reset.

Decomposition:
- The shared cpu_types_pkg gains:
  - fetch_state_t enum (FETCH, HOLD, SQUASH, HALTED);
  - PC_INCR constant = 4;
  - reuses word_t for all WORD_W signals.
- The pc/target register plus the next-pc mux (sequential vs redirect) is a natural sub-module: pc_reg. The FSM and output muxing stay in fetch_unit.

Test Plan:
1. Reset release with ihit=1 every cycle, stall=0, iload=pc-tagged data → imemaddr 0,4,8,…; ifid_writeEN=1 each cycle; pcplus4_out = imemaddr+4.
2. ihit at pc=0x10 with stall=1 held for 3 cycles → imemREN=0 for those cycles and instr_out holds the buffered word. The cycle stall drops: ifid_writeEN=1 for the 0x10 instruction; the next request is at 0x14.
3. redirect_valid with redirect_pc=0x200 while ihit=1 at pc=0x20 → ifid_flush=1, ifid_writeEN=0, 0x20 instruction dropped; next imemaddr=0x200.
4. Miss at pc=0x40 (ihit=0), redirect to 0x300, ihit arrives 4 cycles later → imemaddr stays 0x40 until that ihit; no IF/ID write; then imemaddr=0x300.
5. halt=1 together with redirect_valid (target 0x80) → no halt, fetch resumes at 0x80. Then halt alone → imemREN=0 permanently until nRST.
6. pc=32'hFFFF_FFFC with ihit=1 → pcplus4_out=0, next imemaddr=0. Assert nRST mid-HOLD → all outputs 0 asynchronously, pc=PC_INIT.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, fetch FSM states and PC source selection.
package cpu_types_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam word_t PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // Source of the next PC value held in pc_reg.
  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_SEQ   = 2'd1,
    PC_REDIR = 2'd2,
    PC_TGT   = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// PC register with a parked redirect target and the next-PC mux.
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter int unsigned     W       = 32,
  parameter logic [W-1:0]    PC_INIT = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  pc_sel_t      pc_sel_i,
  input  logic         tgt_we_i,
  input  logic [W-1:0] redirect_pc_i,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_plus4_o
);

  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] tgt_q, tgt_d;

  // Sequential increment wraps modulo 2^W.
  assign pc_plus4_o = pc_q + W'(PC_INCR);
  assign pc_o       = pc_q;

  // Next-PC selection and target capture while a squashed miss drains.
  always_comb begin
    pc_d  = pc_q;
    tgt_d = tgt_q;
    unique case (pc_sel_i)
      PC_KEEP:  pc_d = pc_q;
      PC_SEQ:   pc_d = pc_plus4_o;
      PC_REDIR: pc_d = redirect_pc_i;
      PC_TGT:   pc_d = tgt_q;
      default:  pc_d = pc_q;
    endcase
    if (tgt_we_i) begin
      tgt_d = redirect_pc_i;
    end
  end

  // PC and target state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= PC_INIT;
      tgt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      tgt_q <= tgt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: icache requests, stall buffering, redirects, halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned         WORD_W  = 32,
  parameter logic [WORD_W-1:0]   PC_INIT = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              ifid_writeEN,
  output logic              ifid_flush,
  output logic [WORD_W-1:0] pcplus4_out,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] next_pc_out
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] buf_instr_q, buf_instr_d;
  logic [WORD_W-1:0] buf_pc4_q, buf_pc4_d;
  logic [WORD_W-1:0] pc, pc_plus4;
  pc_sel_t           pc_sel;
  logic              tgt_we;

  logic              ren_raw, we_raw, fl_raw;
  logic [WORD_W-1:0] ins_raw, pc4_raw;

  pc_reg #(
    .W       (WORD_W),
    .PC_INIT (PC_INIT)
  ) u_pc_reg (
    .clk_i         (CLK),
    .rst_ni        (nRST),
    .pc_sel_i      (pc_sel),
    .tgt_we_i      (tgt_we),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4)
  );

  // FSM transitions, PC control, buffer capture and raw output values.
  always_comb begin
    state_d     = state_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    pc_sel      = PC_KEEP;
    tgt_we      = 1'b0;
    ren_raw     = 1'b0;
    we_raw      = 1'b0;
    fl_raw      = 1'b0;
    ins_raw     = '0;
    pc4_raw     = '0;
    unique case (state_q)
      FETCH: begin
        ren_raw = 1'b1;
        ins_raw = iload;
        pc4_raw = pc_plus4;
        if (redirect_valid) begin
          fl_raw = 1'b1;
          if (ihit) begin
            pc_sel = PC_REDIR;
          end else begin
            // Miss in flight: keep requesting the old address, park the target.
            tgt_we  = 1'b1;
            state_d = SQUASH;
          end
        end else if (halt) begin
          state_d = HALTED;
        end else if (ihit && !stall) begin
          we_raw = 1'b1;
          pc_sel = PC_SEQ;
        end else if (ihit) begin
          buf_instr_d = iload;
          buf_pc4_d   = pc_plus4;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        ins_raw = buf_instr_q;
        pc4_raw = buf_pc4_q;
        if (redirect_valid) begin
          fl_raw      = 1'b1;
          pc_sel      = PC_REDIR;
          buf_instr_d = '0;
          buf_pc4_d   = '0;
          state_d     = FETCH;
        end else if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          we_raw  = 1'b1;
          pc_sel  = PC_SEQ;
          state_d = FETCH;
        end
      end
      SQUASH: begin
        ren_raw = 1'b1;
        if (redirect_valid) begin
          fl_raw = 1'b1;
          // A new target that coincides with the miss returning can be taken
          // directly; otherwise it replaces the parked target.
          if (ihit) begin
            pc_sel  = PC_REDIR;
            state_d = FETCH;
          end else begin
            tgt_we = 1'b1;
          end
        end else if (ihit) begin
          pc_sel  = PC_TGT;
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Outputs are forced to zero while reset is asserted.
  always_comb begin
    imemREN      = 1'b0;
    imemaddr     = '0;
    ifid_writeEN = 1'b0;
    ifid_flush   = 1'b0;
    instr_out    = '0;
    pcplus4_out  = '0;
    next_pc_out  = '0;
    if (nRST) begin
      imemREN      = ren_raw;
      imemaddr     = pc;
      ifid_writeEN = we_raw;
      ifid_flush   = fl_raw;
      instr_out    = ins_raw;
      pcplus4_out  = pc4_raw;
      next_pc_out  = pc4_raw;
    end
  end

  // FSM state and stall buffer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= FETCH;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset sequences,
// and random stimulus against a behavioural model.
module tb_fetch_unit;

  logic        CLK, nRST;
  logic        ihit, stall, redirect_valid, halt;
  logic [31:0] iload, redirect_pc;
  logic        imemREN, ifid_writeEN, ifid_flush;
  logic [31:0] imemaddr, pcplus4_out, instr_out, next_pc_out;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .WORD_W  (32),
    .PC_INIT (32'h0000_0000)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .iload          (iload),
    .imemREN        (imemREN),
    .imemaddr       (imemaddr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .ifid_writeEN   (ifid_writeEN),
    .ifid_flush     (ifid_flush),
    .pcplus4_out    (pcplus4_out),
    .instr_out      (instr_out),
    .next_pc_out    (next_pc_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ih;
    logic [31:0] ld;
    logic        st;
    logic        rv;
    logic [31:0] rp;
    logic        hl;
    logic        ren;
    logic [31:0] addr;
    logic        we;
    logic        fl;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        dchk;
    logic        rst;
  } vec_t;

  vec_t tbl[$];

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc4;
  } entry_t;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_squash;
  bit          m_halted;
  entry_t      m_buf[$];

  // Expectations from the model
  logic        e_ren, e_we, e_fl, e_dchk;
  logic [31:0] e_addr, e_ins, e_pc4;

  function automatic void add(logic ih, logic [31:0] ld, logic st, logic rv,
                              logic [31:0] rp, logic hl, logic ren,
                              logic [31:0] addr, logic we, logic fl,
                              logic [31:0] ins, logic [31:0] pc4,
                              logic dchk, logic rst);
    vec_t v;
    v.ih = ih; v.ld = ld; v.st = st; v.rv = rv; v.rp = rp; v.hl = hl;
    v.ren = ren; v.addr = addr; v.we = we; v.fl = fl; v.ins = ins;
    v.pc4 = pc4; v.dchk = dchk; v.rst = rst;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic [31:0] ld, input logic st,
                       input logic rv, input logic [31:0] rp, input logic hl);
    ihit = ih; iload = ld; stall = st;
    redirect_valid = rv; redirect_pc = rp; halt = hl;
  endtask

  task automatic compare(input string tag, input logic ren, input logic [31:0] addr,
                         input logic we, input logic fl, input logic [31:0] ins,
                         input logic [31:0] pc4, input logic dchk);
    chk({tag, " imemREN"}, {31'd0, imemREN}, {31'd0, ren});
    if (ren) chk({tag, " imemaddr"}, imemaddr, addr);
    chk({tag, " writeEN"}, {31'd0, ifid_writeEN}, {31'd0, we});
    chk({tag, " flush"}, {31'd0, ifid_flush}, {31'd0, fl});
    if (dchk) begin
      chk({tag, " instr_out"}, instr_out, ins);
      chk({tag, " pcplus4_out"}, pcplus4_out, pc4);
      chk({tag, " next_pc_out"}, next_pc_out, pc4);
    end
  endtask

  // Called just after a falling edge. Asserts reset mid-cycle, checks that all
  // outputs drop to zero while an instruction is being offered, releases reset
  // away from the rising edge and checks the first request at PC_INIT.
  task automatic reset_pulse();
    #1;
    nRST = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rst imemREN", {31'd0, imemREN}, 32'd0);
    chk("rst imemaddr", imemaddr, 32'd0);
    chk("rst writeEN", {31'd0, ifid_writeEN}, 32'd0);
    chk("rst flush", {31'd0, ifid_flush}, 32'd0);
    chk("rst instr_out", instr_out, 32'd0);
    chk("rst pcplus4_out", pcplus4_out, 32'd0);
    chk("rst next_pc_out", next_pc_out, 32'd0);
    @(posedge CLK);
    #2;
    nRST = 1'b1;
    #1;
    chk("post-rst imemREN", {31'd0, imemREN}, 32'd1);
    chk("post-rst imemaddr", imemaddr, 32'd0);
    // Idle inputs so the next rising edge is a no-op
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    m_pc = 32'h0; m_tgt = 32'h0; m_squash = 0; m_halted = 0;
    m_buf.delete();
  endtask

  // One cycle of the reference: expectations for the current inputs, then the
  // architectural effect of the coming rising edge.
  task automatic ref_step(input logic ih, input logic [31:0] ld, input logic st,
                          input logic rv, input logic [31:0] rp, input logic hl);
    e_ren = 0; e_addr = m_pc; e_we = 0; e_fl = 0;
    e_ins = 32'h0; e_pc4 = 32'h0; e_dchk = 0;
    if (m_halted) begin
      // frozen
    end else if (m_squash) begin
      e_ren = 1; e_fl = rv;
      if (rv) begin
        if (ih) begin m_pc = rp; m_squash = 0; end
        else m_tgt = rp;
      end else if (ih) begin
        m_pc = m_tgt; m_squash = 0;
      end
    end else if (m_buf.size() != 0) begin
      e_fl = rv; e_ins = m_buf[0].ins; e_pc4 = m_buf[0].pc4; e_dchk = 1;
      if (rv) begin
        m_buf.delete(); m_pc = rp;
      end else if (hl) begin
        m_halted = 1;
      end else if (!st) begin
        e_we = 1; m_buf.delete(); m_pc = m_pc + 32'd4;
      end
    end else begin
      e_ren = 1; e_fl = rv; e_ins = ld; e_pc4 = m_pc + 32'd4;
      if (rv) begin
        if (ih) m_pc = rp;
        else begin m_squash = 1; m_tgt = rp; end
      end else if (hl) begin
        m_halted = 1;
      end else if (ih && !st) begin
        e_we = 1; e_dchk = 1; m_pc = m_pc + 32'd4;
      end else if (ih) begin
        m_buf.push_back('{ld, m_pc + 32'd4});
      end
    end
  endtask

  initial begin
    int halted_cycles;
    logic        r_ih, r_st, r_rv, r_hl;
    logic [31:0] r_ld, r_rp;

    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Directed vectors:  ih ld st rv rp hl | ren addr we fl ins pc4 dchk | rst
    // Sequential fetch from reset
    add(1, 32'hA000_0000, 0, 0, 0, 0, 1, 32'h00, 1, 0, 32'hA000_0000, 32'h04, 1, 0);
    add(1, 32'hA000_0004, 0, 0, 0, 0, 1, 32'h04, 1, 0, 32'hA000_0004, 32'h08, 1, 0);
    add(1, 32'hA000_0008, 0, 0, 0, 0, 1, 32'h08, 1, 0, 32'hA000_0008, 32'h0C, 1, 0);
    add(1, 32'hA000_000C, 0, 0, 0, 0, 1, 32'h0C, 1, 0, 32'hA000_000C, 32'h10, 1, 0);
    // Hit under stall at 0x10, held three cycles, released
    add(1, 32'hA000_0010, 1, 0, 0, 0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 0);
    add(0, 32'h5555_5555, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'hA000_0010, 32'h14, 1, 0);
    add(1, 32'h6666_6666, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'hA000_0010, 32'h14, 1, 0);
    add(0, 32'h7777_7777, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'hA000_0010, 32'h14, 1, 0);
    add(0, 32'h8888_8888, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'hA000_0010, 32'h14, 1, 0);
    add(1, 32'hA000_0014, 0, 0, 0, 0, 1, 32'h14, 1, 0, 32'hA000_0014, 32'h18, 1, 0);
    add(1, 32'hA000_0018, 0, 0, 0, 0, 1, 32'h18, 1, 0, 32'hA000_0018, 32'h1C, 1, 0);
    add(1, 32'hA000_001C, 0, 0, 0, 0, 1, 32'h1C, 1, 0, 32'hA000_001C, 32'h20, 1, 0);
    // Redirect on a hit at 0x20
    add(1, 32'hA000_0020, 0, 1, 32'h200, 0, 1, 32'h20, 0, 1, 32'h0, 32'h0, 0, 0);
    add(1, 32'hA000_0200, 0, 0, 0, 0, 1, 32'h200, 1, 0, 32'hA000_0200, 32'h204, 1, 0);
    // Redirect to 0x40, then redirect during the miss at 0x40
    add(1, 32'hA000_0204, 0, 1, 32'h40, 0, 1, 32'h204, 0, 1, 32'h0, 32'h0, 0, 0);
    add(0, 32'h0, 0, 1, 32'h300, 0, 1, 32'h40, 0, 1, 32'h0, 32'h0, 0, 0);
    add(0, 32'h0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0);
    add(0, 32'h0, 1, 0, 0, 0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0);
    add(0, 32'h0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0);
    add(1, 32'hBAD0_0040, 0, 0, 0, 0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 0);
    add(1, 32'hA000_0300, 0, 0, 0, 0, 1, 32'h300, 1, 0, 32'hA000_0300, 32'h304, 1, 0);
    // halt with redirect: redirect wins
    add(1, 32'hA000_0304, 0, 1, 32'h80, 1, 1, 32'h304, 0, 1, 32'h0, 32'h0, 0, 0);
    add(1, 32'hA000_0080, 0, 0, 0, 0, 1, 32'h80, 1, 0, 32'hA000_0080, 32'h84, 1, 0);
    // halt alone: frozen afterwards, redirects ignored
    add(0, 32'h0, 0, 0, 0, 1, 1, 32'h84, 0, 0, 32'h0, 32'h0, 0, 0);
    add(1, 32'hA000_0084, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    add(1, 32'hA000_0084, 0, 0, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    add(1, 32'hA000_0084, 0, 1, 32'h500, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    // After reset: jump to the top word, wrap, then stall into HOLD
    add(1, 32'hA000_0000, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h0, 0, 1, 32'h0, 32'h0, 0, 1);
    add(1, 32'hC0DE_FFFC, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'hC0DE_FFFC, 32'h0, 1, 0);
    add(1, 32'h1234_5678, 1, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    add(0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h1234_5678, 32'h4, 1, 0);

    reset_pulse();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) reset_pulse();
      @(posedge CLK);
      #1;
      drive(tbl[i].ih, tbl[i].ld, tbl[i].st, tbl[i].rv, tbl[i].rp, tbl[i].hl);
      @(negedge CLK);
      compare($sformatf("vec%0d", i), tbl[i].ren, tbl[i].addr, tbl[i].we,
              tbl[i].fl, tbl[i].ins, tbl[i].pc4, tbl[i].dchk);
    end

    // Asynchronous reset while in HOLD
    reset_pulse();

    // Random stimulus against the model
    halted_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      if (halted_cycles > 4 || $urandom_range(0, 499) == 0) begin
        reset_pulse();
        halted_cycles = 0;
      end
      r_ih = ($urandom_range(0, 9) < 7);
      r_st = ($urandom_range(0, 9) < 3);
      r_rv = ($urandom_range(0, 19) == 0);
      r_hl = ($urandom_range(0, 59) == 0);
      r_ld = $urandom();
      case ($urandom_range(0, 3))
        0:       r_rp = 32'hFFFF_FFF8;
        1:       r_rp = $urandom();
        default: r_rp = $urandom() & 32'h0000_FFFC;
      endcase
      if (m_squash && r_rv) r_ih = 1'b0;
      @(posedge CLK);
      #1;
      drive(r_ih, r_ld, r_st, r_rv, r_rp, r_hl);
      @(negedge CLK);
      ref_step(r_ih, r_ld, r_st, r_rv, r_rp, r_hl);
      compare($sformatf("rnd%0d", n), e_ren, e_addr, e_we, e_fl, e_ins, e_pc4, e_dchk);
      if (m_halted) halted_cycles++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
